// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, defaults and line levels for the serial link
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/serial_if.sv
// serial_if: Start/Data handshake plus line and status outputs of the transmitter
interface serial_if import serial_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic Start;
  logic [DATA_W-1:0] Data;
  logic Ready;
  logic TxD;
  logic Done;
  modport master (output Start, Data, input Ready, TxD, Done);
  modport slave (input Start, Data, output Ready, TxD, Done);
endinterface

// File: rtl/bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles per serial bit, Tick on the last one
module bit_timer import serial_pkg::*; #(parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [TW-1:0] r_cnt;
  assign Tick = r_cnt == TW'(CLKS_PER_BIT - 1);
  always_ff @(posedge Clk) begin
    if (Reset || Clear || Tick) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: idle-high serial transmitter, start bit, LSB-first data, even parity, stop bit
module serial_tx import serial_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input logic Clk,
  input logic Reset,
  serial_if.slave s
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [BW-1:0] r_bit;
  logic r_par, r_txd, r_ready, r_done;
  logic w_tick, w_accept, w_last, w_line;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clk(Clk),
    .Reset(Reset),
    .Clear(r_state == IDLE),
    .Tick(w_tick)
  );
  assign w_accept = r_state == IDLE && s.Start;
  assign w_last = r_bit == BW'(DATA_W - 1);
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.Start ? START : IDLE;
      START:   w_next = w_tick ? DATA : START;
      DATA:    w_next = (w_tick && w_last) ? PARITY : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
      STOP:    w_next = w_tick ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // TxD is registered from the next state so the line changes on the same edge as the state
  assign w_shift = w_accept ? s.Data : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
  assign w_line = w_next == START  ? LINE_START :
                  w_next == DATA   ? w_shift[0] :
                  w_next == PARITY ? r_par      : LINE_IDLE;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shift <= '0;
      r_bit <= '0;
      r_par <= 1'b0;
      r_txd <= LINE_IDLE;
      r_ready <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_shift <= w_shift;
      r_bit <= w_accept ? '0 : (r_state == DATA && w_tick && !w_last) ? r_bit + 1'b1 : r_bit;
      r_par <= w_accept ? ^s.Data : r_par;
      r_txd <= w_line;
      r_ready <= w_next == IDLE;
      r_done <= r_state == STOP && w_next == IDLE;
    end
  end
  assign s.TxD = r_txd;
  assign s.Ready = r_ready;
  assign s.Done = r_done;
endmodule
